// File: rtl/jtbubl_romarb_if.sv
// jtbubl_romarb_if: requester ports, SDRAM slot and status of the gfx ROM arbiter.
// slave = arbiter side, master = requesters plus SDRAM controller.
interface jtbubl_romarb_if #(parameter int AW = 18);
    logic          cs0, cs1;
    logic [AW-1:0] addr0, addr1;
    logic          ok0, ok1;
    logic [31:0]   data0, data1;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic          rom_ok;
    logic [1:0]    gnt;
    logic          tout_err;
    modport slave (
        input  cs0, cs1, addr0, addr1, rom_data, rom_ok,
        output ok0, ok1, data0, data1, rom_cs, rom_addr, gnt, tout_err
    );
    modport master (
        output cs0, cs1, addr0, addr1, rom_data, rom_ok,
        input  ok0, ok1, data0, data1, rom_cs, rom_addr, gnt, tout_err
    );
endinterface

// File: rtl/jtbubl_romarb.sv
// jtbubl_romarb: shares one 32-bit gfx ROM SDRAM slot between tile and object fetch, with per-port word cache and watchdog.
// Define JTBUBL_ROMARB_RR_EN for round-robin tie breaking; otherwise requester 0 wins ties.
module jtbubl_romarb #(
    parameter int         AW      = 18,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input logic            clk,
    input logic            rst_n,
    jtbubl_romarb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, WAIT, DONE} state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_tag [2];
    logic [31:0]   r_data [2];
    logic [1:0]    r_ok, r_gnt, w_pend, w_keep;
    logic [AW-1:0] r_addr, w_req_addr;
    logic [7:0]    r_cnt;
    logic          r_tout, w_sel, w_grant, w_cap, w_expire;
`ifdef JTBUBL_ROMARB_RR_EN
    logic          r_last;
`endif

    assign w_pend = {bus.cs1 & ~r_ok[1], bus.cs0 & ~r_ok[0]};
    // a cached word survives only while its requester keeps asking for the tagged address
    assign w_keep = {bus.cs1 && bus.addr1 == r_tag[1], bus.cs0 && bus.addr0 == r_tag[0]};
`ifdef JTBUBL_ROMARB_RR_EN
    assign w_sel = w_pend[1] & (~w_pend[0] | ~r_last);
`else
    assign w_sel = ~w_pend[0];
`endif
    assign w_req_addr = w_sel ? bus.addr1 : bus.addr0;
    assign w_grant    = r_state == IDLE && |w_pend;
    assign w_cap      = r_state == WAIT && bus.rom_ok;
    assign w_expire   = r_state == WAIT && !bus.rom_ok && r_cnt == TIMEOUT - 8'd1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_grant ? SETTLE : IDLE;
            SETTLE:  w_next = WAIT;
            WAIT:    w_next = w_cap ? DONE : (w_expire ? IDLE : WAIT);
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_tag[0]  <= '0;
            r_tag[1]  <= '0;
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_ok      <= '0;
            r_gnt     <= '0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_tout    <= 1'b0;
`ifdef JTBUBL_ROMARB_RR_EN
            r_last    <= 1'b1;
`endif
        end else begin
            r_state <= w_next;
            r_ok    <= w_keep & (r_ok | (w_cap ? r_gnt : 2'b00));
            if (w_grant) begin
                r_gnt        <= w_sel ? 2'b10 : 2'b01;
                r_addr       <= w_req_addr;
                r_tag[w_sel] <= w_req_addr;
                r_cnt        <= '0;
`ifdef JTBUBL_ROMARB_RR_EN
                r_last       <= w_sel;
`endif
            end else if (w_next == IDLE) begin
                r_gnt <= '0;
            end
            if (r_state == WAIT) r_cnt <= r_cnt + 8'd1;
            if (w_expire) r_tout <= 1'b1;
            if (w_cap) r_data[r_gnt[1]] <= bus.rom_data;
        end
    end

    assign bus.rom_cs   = r_state == SETTLE || r_state == WAIT;
    assign bus.rom_addr = r_addr;
    assign bus.ok0      = r_ok[0];
    assign bus.ok1      = r_ok[1];
    assign bus.data0    = r_data[0];
    assign bus.data1    = r_data[1];
    assign bus.gnt      = r_gnt;
    assign bus.tout_err = r_tout;
endmodule

// File: tb/tb_jtbubl_romarb.sv
// tb_jtbubl_romarb: directed scenarios plus randomized traffic against a fetch-level model of the ROM arbiter.
module tb_jtbubl_romarb;
    localparam int AW = 18;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    jtbubl_romarb_if #(.AW(AW)) bus();
    jtbubl_romarb #(.AW(AW), .TIMEOUT(8'(TO))) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // model: cache per requester plus the one fetch in flight (owner, address, cycles since grant)
    logic          m_ok [2];
    logic [AW-1:0] m_tag [2];
    logic [31:0]   m_data [2];
    logic [AW-1:0] m_addr;
    logic          m_tout, m_busy, m_done, m_who;
    int            m_age;
`ifdef JTBUBL_ROMARB_RR_EN
    logic          m_last;
`endif

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ok[k] = 1'b0;
            m_tag[k] = '0;
            m_data[k] = '0;
        end
        m_addr = '0;
        m_tout = 1'b0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_who = 1'b0;
        m_age = 0;
`ifdef JTBUBL_ROMARB_RR_EN
        m_last = 1'b1;
`endif
    endtask

    task automatic model_step();
        logic          cs [2];
        logic [AW-1:0] ad [2];
        logic          nok [2];
        logic [1:0]    pend;
        logic          cap, expire, w;
        cs[0] = bus.cs0;
        cs[1] = bus.cs1;
        ad[0] = bus.addr0;
        ad[1] = bus.addr1;
        for (int k = 0; k < 2; k++) pend[k] = cs[k] & !m_ok[k];
        cap    = m_busy && !m_done && m_age >= 1 && bus.rom_ok;
        expire = m_busy && !m_done && m_age >= TO && !bus.rom_ok;
        for (int k = 0; k < 2; k++)
            nok[k] = cs[k] && ad[k] == m_tag[k] && (m_ok[k] || (cap && int'(m_who) == k));
        if (cap) begin
            m_data[m_who] = bus.rom_data;
            m_done = 1'b1;
        end else if (expire) begin
            m_tout = 1'b1;
            m_busy = 1'b0;
        end else if (m_done) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_busy) begin
            m_age++;
        end else if (pend != 2'b00) begin
`ifdef JTBUBL_ROMARB_RR_EN
            w = (pend == 2'b11) ? !m_last : pend[1];
            m_last = w;
`else
            w = !pend[0];
`endif
            m_busy = 1'b1;
            m_age = 0;
            m_who = w;
            m_addr = ad[w];
            m_tag[w] = ad[w];
        end
        m_ok = nok;
    endtask

    task automatic compare();
        chk("rom_cs", 64'(bus.rom_cs), 64'(m_busy && !m_done));
        chk("rom_addr", 64'(bus.rom_addr), 64'(m_addr));
        chk("gnt", 64'(bus.gnt), 64'(m_busy ? (m_who ? 2'b10 : 2'b01) : 2'b00));
        chk("ok0", 64'(bus.ok0), 64'(m_ok[0]));
        chk("ok1", 64'(bus.ok1), 64'(m_ok[1]));
        chk("data0", 64'(bus.data0), 64'(m_data[0]));
        chk("data1", 64'(bus.data1), 64'(m_data[1]));
        chk("tout_err", 64'(bus.tout_err), 64'(m_tout));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    // called between edges: reset takes effect with no clock, released before the next rising edge
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rom_cs", 64'(bus.rom_cs), 64'h0);
        chk("rst_gnt", 64'(bus.gnt), 64'h0);
        chk("rst_ok0", 64'(bus.ok0), 64'h0);
        chk("rst_ok1", 64'(bus.ok1), 64'h0);
        chk("rst_tout", 64'(bus.tout_err), 64'h0);
        chk("rst_data0", 64'(bus.data0), 64'h0);
        chk("rst_rom_addr", 64'(bus.rom_addr), 64'h0);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        bus.cs0 = 1'b0;
        bus.cs1 = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.rom_ok = 1'b0;
        bus.rom_data = '0;
        model_reset();
        @(negedge clk);
        do_reset();
        tick();

        bus.cs0 = 1'b1;
        bus.addr0 = 18'h00123;
        bus.rom_ok = 1'b1;
        bus.rom_data = 32'hDEADBEEF;
        tick();
        chk("sf_cs_c1", 64'(bus.rom_cs), 64'h1);
        chk("sf_ok0_c1", 64'(bus.ok0), 64'h0);
        tick();
        chk("sf_cs_c2", 64'(bus.rom_cs), 64'h1);
        chk("sf_ok0_c2", 64'(bus.ok0), 64'h0);
        tick();
        chk("sf_ok0_c3", 64'(bus.ok0), 64'h1);
        chk("sf_data0", 64'(bus.data0), 64'hDEADBEEF);
        chk("sf_cs_c3", 64'(bus.rom_cs), 64'h0);
        chk("sf_model_ok0", 64'(m_ok[0]), 64'h1);
        repeat (4) tick();
        chk("sf_hit_ok0", 64'(bus.ok0), 64'h1);
        chk("sf_hit_cs", 64'(bus.rom_cs), 64'h0);
        chk("sf_ok1", 64'(bus.ok1), 64'h0);

        do_reset();
        bus.addr0 = 18'h10;
        bus.cs1 = 1'b1;
        bus.addr1 = 18'h20;
        bus.rom_data = 32'h11110000;
        tick();
        chk("tie_first_addr", 64'(bus.rom_addr), 64'h10);
        chk("tie_first_gnt", 64'(bus.gnt), 64'h1);
        repeat (4) tick();
        chk("tie_second_addr", 64'(bus.rom_addr), 64'h20);
        chk("tie_second_gnt", 64'(bus.gnt), 64'h2);
        chk("tie_data0", 64'(bus.data0), 64'h11110000);
        chk("tie_model_addr", 64'(m_addr), 64'h20);

        do_reset();
        bus.cs0 = 1'b0;
        bus.cs1 = 1'b1;
        bus.addr1 = 18'h40;
        bus.rom_ok = 1'b0;
        bus.rom_data = 32'hA1A1A1A1;
        tick();
        tick();
        bus.addr1 = 18'h41;
        bus.rom_ok = 1'b1;
        tick();
        chk("mc_ok1_stale", 64'(bus.ok1), 64'h0);
        chk("mc_data1_stale", 64'(bus.data1), 64'hA1A1A1A1);
        bus.rom_data = 32'hB2B2B2B2;
        tick();
        tick();
        chk("mc_refetch_addr", 64'(bus.rom_addr), 64'h41);
        chk("mc_refetch_gnt", 64'(bus.gnt), 64'h2);
        tick();
        tick();
        chk("mc_ok1", 64'(bus.ok1), 64'h1);
        chk("mc_data1", 64'(bus.data1), 64'hB2B2B2B2);

        do_reset();
        bus.cs1 = 1'b0;
        bus.cs0 = 1'b1;
        bus.addr0 = 18'h55;
        bus.rom_ok = 1'b0;
        tick();
        tick();
        repeat (TO - 1) tick();
        chk("wd_cs_before", 64'(bus.rom_cs), 64'h1);
        chk("wd_tout_before", 64'(bus.tout_err), 64'h0);
        tick();
        chk("wd_tout", 64'(bus.tout_err), 64'h1);
        chk("wd_cs_low", 64'(bus.rom_cs), 64'h0);
        chk("wd_gnt_idle", 64'(bus.gnt), 64'h0);
        chk("wd_ok0", 64'(bus.ok0), 64'h0);
        tick();
        chk("wd_retry_cs", 64'(bus.rom_cs), 64'h1);
        chk("wd_retry_addr", 64'(bus.rom_addr), 64'h55);
        chk("wd_model_tout", 64'(m_tout), 64'h1);

        tick();
        bus.rom_data = 32'h5A5A5A5A;
        do_reset();
        bus.rom_ok = 1'b1;
        tick();
        tick();
        chk("rr_ok0_c2", 64'(bus.ok0), 64'h0);
        tick();
        chk("rr_ok0_c3", 64'(bus.ok0), 64'h1);
        chk("rr_data0", 64'(bus.data0), 64'h5A5A5A5A);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.cs0 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) bus.cs1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) bus.addr0 = AW'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) bus.addr1 = AW'($urandom_range(0, 3));
            bus.rom_ok = $urandom_range(0, 9) < 4;
            bus.rom_data = $urandom;
            if ($urandom_range(0, 999) == 0) do_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
